// File: rtl/lsu_bus_interface.sv
// ============================================================================
// Module   : lsu_bus_interface
// Brief    : Load/store bus interface for the multi-cycle RV32I MEM state.
//            One word-aligned access per request, ready handshake, timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_bus_interface #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_rd,
   input  logic        i_req_wr,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [2:0]  i_funct3,
   output logic        o_stall,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_load_data,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ready,
   input  logic [31:0] i_mem_rdata
);

   localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [2:0]         r_f3;
   logic [1:0]         r_lane;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_done;
   logic               r_err;
   logic [31:0]        r_load_data;
   logic               r_mem_req;
   logic               r_mem_we;
   logic [31:0]        r_mem_addr;
   logic [3:0]         r_mem_be;
   logic [31:0]        r_mem_wdata;

   logic               w_req_any;
   logic               w_illegal;
   logic               w_misaligned;
   logic               w_reject;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata_rep;
   logic [31:0]        w_shift;
   logic [31:0]        w_ext;

   assign w_req_any    = i_req_rd | i_req_wr;
   assign w_illegal    = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111)
                         || (i_req_wr && i_funct3[2]);
   assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0])
                         || ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
   assign w_reject     = (i_req_rd & i_req_wr) | w_illegal | w_misaligned;

   always_comb begin
      w_be        = 4'b1111;
      w_wdata_rep = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin
            w_be        = 4'b0001 << i_addr[1:0];
            w_wdata_rep = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_rep = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Bring the addressed lane down to bit 0 before extension.
   assign w_shift = i_mem_rdata >> {r_lane, 3'b000};

   always_comb begin
      w_ext = i_mem_rdata;
      case (r_f3)
         3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_ext = {24'd0, w_shift[7:0]};
         3'b101:  w_ext = {16'd0, w_shift[15:0]};
         default: w_ext = i_mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_f3        <= 3'd0;
         r_lane      <= 2'd0;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_load_data <= 32'd0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_be    <= 4'd0;
         r_mem_wdata <= 32'd0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req_any) begin
                  r_f3   <= i_funct3;
                  r_lane <= i_addr[1:0];
                  if (w_reject) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state     <= S_REQ;
                     r_cnt       <= '0;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= i_req_wr;
                     r_mem_addr  <= {i_addr[31:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata_rep;
                  end
               end
            end
            S_REQ: begin
               if (i_mem_ready) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_mem_req <= 1'b0;
                  if (!r_mem_we) begin
                     r_load_data <= w_ext;
                  end
               end else if ((TIMEOUT != 0) && (r_cnt == c_tmo_last)) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
                  r_mem_req <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_stall     = ((r_state == S_IDLE) & w_req_any) | (r_state == S_REQ);
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_load_data = r_load_data;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_be    = r_mem_be;
   assign o_mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_interface.sv
// ============================================================================
// Module   : tb_lsu_bus_interface
// Brief    : Scoreboard bench for lsu_bus_interface built with TIMEOUT = 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus_interface;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_rd, i_req_wr;
   logic [31:0] i_addr, i_wdata;
   logic [2:0]  i_funct3;
   logic        o_stall, o_done, o_err;
   logic [31:0] o_load_data;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ready;
   logic [31:0] i_mem_rdata;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [32:0] sb_q[$];
   logic [31:0] exp_ld = 32'd0;

   always #5 clk = ~clk;

   lsu_bus_interface #(.TIMEOUT(TMO)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_rd    (i_req_rd),
      .i_req_wr    (i_req_wr),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .i_funct3    (i_funct3),
      .o_stall     (o_stall),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_load_data (o_load_data),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_be    (o_mem_be),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_ready (i_mem_ready),
      .i_mem_rdata (i_mem_rdata)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (o_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [32:0] e;
            e = sb_q.pop_front();
            check_val("sb_err", {31'd0, o_err}, {31'd0, e[32]});
            check_val("sb_load_data", o_load_data, e[31:0]);
            check_val("sb_stall_in_done", {31'd0, o_stall}, 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // waits < 0 means mem_ready is never given, exercising the timeout.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                         input int waits, input logic [31:0] rdata, input logic rej,
                         input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld);
      logic to;
      int   n;
      to = (waits < 0);
      i_req_rd = rd;
      i_req_wr = wr;
      i_addr   = a;
      i_wdata  = wd;
      i_funct3 = f3;
      #1;
      check_val({tag, "_stall_req"}, {31'd0, o_stall}, 32'd1);
      if (!rej && !to && rd && !wr) exp_ld = eld;
      sb_q.push_back({rej | to, exp_ld});
      step();
      if (!rej) begin
         n = to ? TMO : waits + 1;
         for (int c = 0; c < n; c++) begin
            check_val({tag, "_mem_req"}, {31'd0, o_mem_req}, 32'd1);
            check_val({tag, "_stall"}, {31'd0, o_stall}, 32'd1);
            if (c == 0) begin
               check_val({tag, "_mem_we"}, {31'd0, o_mem_we}, {31'd0, wr});
               check_val({tag, "_mem_addr"}, o_mem_addr, {a[31:2], 2'b00});
               check_val({tag, "_mem_be"}, {28'd0, o_mem_be}, {28'd0, ebe});
               if (wr) check_val({tag, "_mem_wdata"}, o_mem_wdata, ewd);
            end
            i_mem_ready = !to && (c == waits);
            i_mem_rdata = (c == waits) ? rdata : ~rdata;
            step();
            i_mem_ready = 1'b0;
         end
      end
      check_val({tag, "_done"}, {31'd0, o_done}, 32'd1);
      check_val({tag, "_mem_req_off"}, {31'd0, o_mem_req}, 32'd0);
      i_req_rd = 1'b0;
      i_req_wr = 1'b0;
      step();
      check_val({tag, "_idle_stall"}, {31'd0, o_stall}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      i_req_rd = 1'b0;  i_req_wr = 1'b0;
      i_addr = 32'd0;   i_wdata = 32'd0;  i_funct3 = 3'd0;
      i_mem_ready = 1'b0; i_mem_rdata = 32'd0;
      step(); step();
      check_val("rst_stall", {31'd0, o_stall}, 32'd0);
      check_val("rst_done", {31'd0, o_done}, 32'd0);
      check_val("rst_err", {31'd0, o_err}, 32'd0);
      check_val("rst_load_data", o_load_data, 32'd0);
      check_val("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
      check_val("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
      check_val("rst_mem_addr", o_mem_addr, 32'd0);
      check_val("rst_mem_be", {28'd0, o_mem_be}, 32'd0);
      check_val("rst_mem_wdata", o_mem_wdata, 32'd0);
      rst = 1'b0;
      step();

      //     tag      rd    wr    addr          wdata         f3     waits rdata         rej   be       wdata         load_data
      access("lw",    1'b1, 1'b0, 32'h0000_0100, 32'h0,        3'b010, 0,  32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
      access("lb",    1'b1, 1'b0, 32'h0000_0103, 32'h0,        3'b000, 2,  32'h8000_0000, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80);
      access("lbu",   1'b1, 1'b0, 32'h0000_0103, 32'h0,        3'b100, 2,  32'h8000_0000, 1'b0, 4'b1000, 32'h0,        32'h0000_0080);
      access("lh",    1'b1, 1'b0, 32'h0000_0102, 32'h0,        3'b001, 1,  32'h8001_1234, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001);
      access("lhu",   1'b1, 1'b0, 32'h0000_0102, 32'h0,        3'b101, 0,  32'h8001_1234, 1'b0, 4'b1100, 32'h0,        32'h0000_8001);
      access("lb0",   1'b1, 1'b0, 32'h0000_0104, 32'h0,        3'b000, 0,  32'h1234_567F, 1'b0, 4'b0001, 32'h0,        32'h0000_007F);
      access("sh",    1'b0, 1'b1, 32'h0000_0202, 32'h1234_ABCD, 3'b001, 0, 32'h0,         1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
      access("sb",    1'b0, 1'b1, 32'h0000_0201, 32'h0000_0055, 3'b000, 1, 32'h0,         1'b0, 4'b0010, 32'h5555_5555, 32'h0);
      access("sw",    1'b0, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 3'b010, 3, 32'h0,         1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0);
      access("lw_mis",1'b1, 1'b0, 32'h0000_0101, 32'h0,        3'b010, 0,  32'h0,         1'b1, 4'b0000, 32'h0,        32'h0);
      access("both",  1'b1, 1'b1, 32'h0000_0100, 32'h0,        3'b010, 0,  32'h0,         1'b1, 4'b0000, 32'h0,        32'h0);
      access("lh_mis",1'b1, 1'b0, 32'h0000_0103, 32'h0,        3'b001, 0,  32'h0,         1'b1, 4'b0000, 32'h0,        32'h0);
      access("sbu",   1'b0, 1'b1, 32'h0000_0100, 32'h0,        3'b100, 0,  32'h0,         1'b1, 4'b0000, 32'h0,        32'h0);
      access("f3_011",1'b1, 1'b0, 32'h0000_0100, 32'h0,        3'b011, 0,  32'h0,         1'b1, 4'b0000, 32'h0,        32'h0);
      access("tmo",   1'b1, 1'b0, 32'h0000_0400, 32'h0,        3'b010, -1, 32'h1111_2222, 1'b0, 4'b1111, 32'h0,        32'h0);
      check_val("tmo_load_kept", o_load_data, 32'h0000_007F);

      // A stray mem_ready while idle must not produce a completion.
      i_mem_ready = 1'b1;
      i_mem_rdata = 32'h5A5A_5A5A;
      step(); step();
      i_mem_ready = 1'b0;
      check_val("idle_ready_mem_req", {31'd0, o_mem_req}, 32'd0);
      check_val("idle_ready_load", o_load_data, 32'h0000_007F);

      // Reset on the second REQ cycle.
      i_req_rd = 1'b1;
      i_addr   = 32'h0000_0500;
      i_funct3 = 3'b010;
      step();
      check_val("mid_rst_req1", {31'd0, o_mem_req}, 32'd1);
      step();
      check_val("mid_rst_req2", {31'd0, o_mem_req}, 32'd1);
      rst = 1'b1;
      i_req_rd = 1'b0;
      step();
      check_val("mid_rst_mem_req", {31'd0, o_mem_req}, 32'd0);
      check_val("mid_rst_load", o_load_data, 32'd0);
      check_val("mid_rst_done", {31'd0, o_done}, 32'd0);
      check_val("mid_rst_stall", {31'd0, o_stall}, 32'd0);
      check_val("mid_rst_mem_be", {28'd0, o_mem_be}, 32'd0);
      check_val("mid_rst_mem_addr", o_mem_addr, 32'd0);
      rst = 1'b0;
      exp_ld = 32'd0;
      step(); step(); step();

      access("lw_post", 1'b1, 1'b0, 32'h0000_0600, 32'h0, 3'b010, 0, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0, 32'h0BAD_F00D);
      step();
      check_val("sb_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lsu_bus_interface.md
# lsu_bus_interface

Load/store bus interface sitting directly downstream of the multi-cycle RV32I control unit's MEM state. Takes the read/write strobes, ALU-computed address, store data and funct3 and runs one word-aligned memory transaction with a ready handshake and wait states. Returns size-extended load data to the writeback path and stalls the control FSM until the access completes, is rejected as misaligned, or times out.

## Interface
- TIMEOUT, 16, max cycles to wait for mem_ready; 0 disables the timeout
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_rd  in  1  load request, level, held by control unit in MEM state
- req_wr  in  1  store request, level, held by control unit in MEM state
- addr  in  32  byte address (ALU output)
- wdata  in  32  store data (rs2)
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- stall  out  1  hold control FSM in MEM state
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done: misaligned, illegal or timeout
- load_data  out  32  extended load result, held until next successful load
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, addr[1:0] forced 00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  bus accepts/completes the access this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1

## Operation
- States: IDLE, REQ, DONE.
- IDLE: on req_rd^req_wr, capture addr, wdata, funct3, direction. Aligned → REQ. Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=00) or illegal funct3 (011, 110, 111; or 1xx on a store) → DONE with err, no bus access.
- req_rd and req_wr both high → DONE with err, no bus access.
- REQ: mem_req=1, mem_we/mem_addr/mem_be/mem_wdata driven from captured registers, stable until mem_ready. On mem_ready: load latches extracted data into load_data; → DONE.
- Timeout: counter cleared on entering REQ, increments each REQ cycle without mem_ready; at TIMEOUT → DONE with err, load_data unchanged.
- DONE: done=1 (err=1 if failure), stall=0; → IDLE. Requests sampled in DONE ignored.
- Byte enables: B: 0001<<addr[1:0]; H: 0011 (addr[1]=0) or 1100; W: 1111. Loads use the same be.
- Store data: B replicates wdata[7:0] to all 4 lanes; H replicates wdata[15:0] to both halves; W passes through.
- Load extraction: select lane by captured addr[1:0]; B/H sign-extend from bit 7/15; BU/HU zero-extend; W pass through.

## Timing
- stall = (IDLE & (req_rd|req_wr)) | REQ; combinational, so the FSM holds MEM from the first request cycle.
- Zero-wait access: request cycle N (IDLE), mem_req cycle N+1 with mem_ready=1, done and load_data valid cycle N+2. Each wait state adds one cycle.
- Rejected access: done/err in cycle N+1, mem_req never asserted.
- Timeout: mem_req high exactly TIMEOUT cycles; done/err in the next cycle.
- Reset values: state IDLE, stall 0, done 0, err 0, load_data 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, counter 0.
- Reset mid-REQ: mem_req low in the cycle after the reset edge; no done, load_data cleared.
- mem_ready outside REQ is ignored.

## Test plan
- LW addr 0x100, mem_rdata 0xDEADBEEF, 0 waits -> mem_addr 0x100, mem_be 1111, done at N+2, load_data 0xDEADBEEF.
- LB addr 0x103, mem_rdata 0x80000000, 2 waits -> mem_req high 3 cycles, load_data 0xFFFFFF80; LBU same access -> 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD -> mem_we 1, mem_addr 0x200, mem_be 1100, mem_wdata 0xABCDABCD, done without err.
- LW addr 0x101 -> done+err at N+1, mem_req never high, load_data unchanged; req_rd=req_wr=1 -> same.
- TIMEOUT=4, mem_ready held low -> mem_req high 4 cycles, then done+err, stall low.
- rst asserted on the second REQ cycle -> mem_req 0 next cycle, no done, all outputs at reset values.
